// File: rtl/wash_mode_sequencer_if.sv
// Panel/datapath bundle for the wash-mode sequencer.
// Carries the panel pulses, the lid/finish levels and the registered outputs.
// Master drives the inputs, the sequencer is the slave.
interface wash_mode_sequencer_if;
   logic        tick;
   logic        power_btn;
   logic        start_btn;
   logic        mode_btn;
   logic        lid_open;
   logic        had_finish;
   logic [2:0]  state;
   logic [25:0] data;
   logic [1:0]  prog;
   logic [2:0]  phase_cnt;
   logic        buzzer;

   modport master (
      output tick, power_btn, start_btn, mode_btn, lid_open, had_finish,
      input  state, data, prog, phase_cnt, buzzer
   );

   modport slave (
      input  tick, power_btn, start_btn, mode_btn, lid_open, had_finish,
      output state, data, prog, phase_cnt, buzzer
   );
endinterface

// File: rtl/wash_mode_sequencer.sv
// Washing-machine run-path state sequencer with program select and phase timers.
// Latency: 1 clk from any input event to the registered outputs.
// No backpressure: inputs are pulses/levels, one event acts per cycle by priority.
module wash_mode_sequencer #(
   parameter int unsigned BEGIN_TICKS  = 2,
   parameter int unsigned FINISH_TICKS = 5,
   parameter logic [25:0] PROG0 = 26'h0841041,
   parameter logic [25:0] PROG1 = 26'h1082082,
   parameter logic [25:0] PROG2 = 26'h18C30C3,
   parameter logic [25:0] PROG3 = 26'h2104104
) (
   input  logic                  clk,
   input  logic                  rst_n,
   wash_mode_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_SHUTDOWN = 3'd0,
      S_BEGIN    = 3'd1,
      S_SET      = 3'd2,
      S_RUN      = 3'd3,
      S_ERROR    = 3'd4,
      S_PAUSE    = 3'd5,
      S_FINISH   = 3'd6
   } state_t;

   localparam logic [2:0] BEGIN_LD  = 3'(BEGIN_TICKS);
   localparam logic [2:0] FINISH_LD = 3'(FINISH_TICKS);

   state_t      state_q, state_d;
   logic [1:0]  prog_q, prog_d;
   logic [25:0] data_q, data_d;
   logic [2:0]  phase_q, phase_d;
   logic        buzzer_q, buzzer_d;

   // Next state, program and phase counter; power overrides everything, then per-state priority.
   always_comb begin
      state_d  = state_q;
      prog_d   = prog_q;
      phase_d  = phase_q;
      if (bus.power_btn) begin
         if (state_q == S_SHUTDOWN) begin
            state_d = S_BEGIN;
            phase_d = BEGIN_LD;
         end else begin
            state_d = S_SHUTDOWN;
            phase_d = 3'd0;
         end
      end else begin
         case (state_q)
            S_SHUTDOWN: ;
            S_BEGIN: begin
               if (bus.tick) begin
                  if (phase_q <= 3'd1) begin
                     state_d = S_SET;
                     phase_d = 3'd0;
                  end else begin
                     phase_d = phase_q - 3'd1;
                  end
               end
            end
            S_SET: begin
               if (bus.start_btn) begin
                  state_d = bus.lid_open ? S_ERROR : S_RUN;
               end else if (bus.mode_btn) begin
                  prog_d = prog_q + 2'd1;
               end
            end
            S_RUN: begin
               if (bus.lid_open) begin
                  state_d = S_ERROR;
               end else if (bus.had_finish) begin
                  state_d = S_FINISH;
                  phase_d = FINISH_LD;
               end else if (bus.start_btn) begin
                  state_d = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (bus.lid_open) begin
                  state_d = S_ERROR;
               end else if (bus.start_btn) begin
                  state_d = S_RUN;
               end
            end
            S_ERROR: begin
               if (!bus.lid_open) begin
                  state_d = S_PAUSE;
               end
            end
            S_FINISH: begin
               if (bus.tick) begin
                  if (phase_q <= 3'd1) begin
                     state_d = S_SHUTDOWN;
                     phase_d = 3'd0;
                  end else begin
                     phase_d = phase_q - 3'd1;
                  end
               end
            end
            default: begin
               state_d = S_SHUTDOWN;
               phase_d = 3'd0;
            end
         endcase
      end
   end

   // Program word lookup and alarm decode from the next-state values.
   always_comb begin
      data_d = PROG0;
      case (prog_d)
         2'd0: data_d = PROG0;
         2'd1: data_d = PROG1;
         2'd2: data_d = PROG2;
         2'd3: data_d = PROG3;
         default: data_d = PROG0;
      endcase
      buzzer_d = (state_d == S_ERROR) || (state_d == S_FINISH);
   end

   // Output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_SHUTDOWN;
         prog_q   <= 2'd0;
         data_q   <= PROG0;
         phase_q  <= 3'd0;
         buzzer_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         prog_q   <= prog_d;
         data_q   <= data_d;
         phase_q  <= phase_d;
         buzzer_q <= buzzer_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.prog      = prog_q;
   assign bus.data      = data_q;
   assign bus.phase_cnt = phase_q;
   assign bus.buzzer    = buzzer_q;

endmodule

// File: tb/tb_wash_mode_sequencer.sv
// Self-checking bench: directed vector table, async reset sequence, random vs model.
// Latency: each vector is checked 1 ns after the clock edge that samples it.
// No backpressure: stimulus applied every cycle.
module tb_wash_mode_sequencer;

   localparam logic [25:0] P0 = 26'h0841041;
   localparam logic [25:0] P1 = 26'h1082082;
   localparam logic [25:0] P2 = 26'h18C30C3;
   localparam logic [25:0] P3 = 26'h2104104;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   wash_mode_sequencer_if bus_if();

   wash_mode_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit pw, st, md, ld, fn, tk;
      int s, p, ph;
      bit bz;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit pw, bit st, bit md, bit ld, bit fn, bit tk,
                               int s, int p, int ph, bit bz);
      vec_t v;
      v.pw = pw; v.st = st; v.md = md; v.ld = ld; v.fn = fn; v.tk = tk;
      v.s = s; v.p = p; v.ph = ph; v.bz = bz;
      return v;
   endfunction

   function automatic logic [25:0] progw(int p);
      case (p)
         0: return P0;
         1: return P1;
         2: return P2;
         default: return P3;
      endcase
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(bit pw, bit st, bit md, bit ld, bit fn, bit tk);
      bus_if.power_btn  = pw;
      bus_if.start_btn  = st;
      bus_if.mode_btn   = md;
      bus_if.lid_open   = ld;
      bus_if.had_finish = fn;
      bus_if.tick       = tk;
   endtask

   task automatic check_all(string tag, int s, int p, int ph, bit bz);
      chk({tag, ".state"},     int'(bus_if.state), s);
      chk({tag, ".prog"},      int'(bus_if.prog), p);
      chk({tag, ".data"},      int'(bus_if.data), int'(progw(p)));
      chk({tag, ".phase_cnt"}, int'(bus_if.phase_cnt), ph);
      chk({tag, ".buzzer"},    int'(bus_if.buzzer), int'(bz));
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Reference model: machine described by its state number, program index and seconds left.
   int m_s, m_p, m_ph;

   task automatic model_step(bit pw, bit st, bit md, bit ld, bit fn, bit tk);
      bit active = (m_s == 3) || (m_s == 5);
      if (pw) begin
         if (m_s == 0) begin m_s = 1; m_ph = 2; end
         else begin m_s = 0; m_ph = 0; end
      end else if (ld && active) begin
         m_s = 4;
      end else if (!ld && m_s == 4) begin
         m_s = 5;
      end else if (fn && m_s == 3) begin
         m_s = 6; m_ph = 5;
      end else if (st && m_s == 2) begin
         m_s = ld ? 4 : 3;
      end else if (st && m_s == 3) begin
         m_s = 5;
      end else if (st && m_s == 5) begin
         m_s = 3;
      end else if (md && m_s == 2) begin
         m_p = (m_p + 1) % 4;
      end else if (tk && (m_s == 1 || m_s == 6)) begin
         m_ph = m_ph - 1;
         if (m_ph == 0) m_s = (m_s == 1) ? 2 : 0;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("reset", 0, 0, 0, 0);

      //            pw st md ld fn tk   s  p ph bz
      vecs.push_back(mk(1,0,0,0,0,0,  1, 0, 2, 0));
      vecs.push_back(mk(0,0,0,0,0,1,  1, 0, 1, 0));
      vecs.push_back(mk(0,0,0,0,0,1,  2, 0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,  2, 1, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,  2, 2, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,  2, 3, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,  2, 0, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,  2, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,0,0,  3, 1, 0, 0));
      vecs.push_back(mk(0,0,0,1,0,0,  4, 1, 0, 1));
      vecs.push_back(mk(0,0,0,0,0,0,  5, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,0,0,  3, 1, 0, 0));
      vecs.push_back(mk(0,0,0,0,1,0,  6, 1, 5, 1));
      vecs.push_back(mk(0,0,0,0,0,1,  6, 1, 4, 1));
      vecs.push_back(mk(0,0,0,0,0,1,  6, 1, 3, 1));
      vecs.push_back(mk(0,0,0,0,0,1,  6, 1, 2, 1));
      vecs.push_back(mk(0,0,0,0,0,1,  6, 1, 1, 1));
      vecs.push_back(mk(0,0,0,0,0,1,  0, 1, 0, 0));
      vecs.push_back(mk(1,0,0,0,0,0,  1, 1, 2, 0));
      vecs.push_back(mk(0,0,0,0,0,1,  1, 1, 1, 0));
      vecs.push_back(mk(0,0,0,0,0,1,  2, 1, 0, 0));
      vecs.push_back(mk(0,1,0,1,0,0,  4, 1, 0, 1));
      vecs.push_back(mk(0,1,0,1,0,0,  4, 1, 0, 1));
      vecs.push_back(mk(0,0,0,0,0,0,  5, 1, 0, 0));
      vecs.push_back(mk(0,0,0,0,1,0,  5, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,0,0,  3, 1, 0, 0));
      vecs.push_back(mk(1,1,0,1,0,0,  0, 1, 0, 0));
      vecs.push_back(mk(1,0,0,0,0,0,  1, 1, 2, 0));
      vecs.push_back(mk(0,1,1,1,0,1,  1, 1, 1, 0));
      vecs.push_back(mk(0,0,0,0,0,1,  2, 1, 0, 0));
      vecs.push_back(mk(0,1,1,0,0,0,  3, 1, 0, 0));
      vecs.push_back(mk(0,0,1,0,0,0,  3, 1, 0, 0));
      vecs.push_back(mk(0,1,0,0,1,0,  6, 1, 5, 1));
      vecs.push_back(mk(0,1,0,0,0,1,  6, 1, 4, 1));
      vecs.push_back(mk(1,0,0,0,0,0,  0, 1, 0, 0));

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].pw, vecs[i].st, vecs[i].md, vecs[i].ld, vecs[i].fn, vecs[i].tk);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].p, vecs[i].ph, vecs[i].bz);
      end

      // Asynchronous reset in the middle of RUN with program 2 selected.
      do_reset();
      drive(1,0,0,0,0,0); @(posedge clk); #1;
      drive(0,0,0,0,0,1); @(posedge clk); #1;
      drive(0,0,0,0,0,1); @(posedge clk); #1;
      drive(0,0,1,0,0,0); @(posedge clk); #1;
      drive(0,0,1,0,0,0); @(posedge clk); #1;
      drive(0,1,0,0,0,0); @(posedge clk); #1;
      drive(0,0,0,0,0,0);
      check_all("pre_rst", 3, 2, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      drive(1,0,0,0,0,0);
      @(posedge clk); #1;
      check_all("post_rst", 1, 0, 2, 0);

      // Randomized run against the reference model.
      do_reset();
      m_s = 0; m_p = 0; m_ph = 0;
      begin
         bit lid = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            bit pw = ($urandom_range(0, 19) == 0);
            bit st = ($urandom_range(0, 3) == 0);
            bit md = ($urandom_range(0, 2) == 0);
            bit fn = ($urandom_range(0, 5) == 0);
            bit tk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) lid = ~lid;
            drive(pw, st, md, lid, fn, tk);
            @(posedge clk);
            #1;
            model_step(pw, st, md, lid, fn, tk);
            check_all($sformatf("rnd%0d", c), m_s, m_p, m_ph, (m_s == 4) || (m_s == 6));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wash_mode_sequencer.md
# wash_mode_sequencer

Top-level state sequencer for the washing-machine run path. Turns debounced panel pulses (power, start/pause, program select), the lid sensor and the run-done flag into the 3-bit machine state consumed by the run countdown datapath. Selects and drives the 26-bit program word (`data`) that the datapath loads. Times the power-on greeting and the finish-alarm phases itself, from a 1 Hz enable pulse.

## Interface
Parameters:
- `BEGIN_TICKS`, default 2: seconds spent in BEGIN after power-on (1..7).
- `FINISH_TICKS`, default 5: seconds spent in FINISH before auto shutdown (1..7).
- `PROG0`, default 26'h0841041: program word for program 0.
- `PROG1`, default 26'h1082082: program word for program 1.
- `PROG2`, default 26'h18C30C3: program word for program 2.
- `PROG3`, default 26'h2104104: program word for program 3.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `tick`, in, 1: one-`clk`-wide 1 Hz enable pulse.
- `power_btn`, in, 1: single-cycle pulse that toggles power.
- `start_btn`, in, 1: single-cycle pulse for start/pause.
- `mode_btn`, in, 1: single-cycle pulse that advances the program.
- `lid_open`, in, 1: level, 1 = lid open.
- `had_finish`, in, 1: level from the datapath, 1 = all program fields have reached zero.
- `state`, out, 3: SHUTDOWN=0, BEGIN=1, SET=2, RUN=3, ERROR=4, PAUSE=5, FINISH=6. Value 7 is never driven.
- `data`, out, 26: program word for the selected program.
- `prog`, out, 2: index of the selected program.
- `phase_cnt`, out, 3: seconds remaining in BEGIN or FINISH; 0 in every other state.
- `buzzer`, out, 1: 1 in ERROR and FINISH.

## Operation
- All outputs are registered.
- Reset values: `state`=0, `prog`=0, `data`=PROG0, `phase_cnt`=0, `buzzer`=0.
- When more than one event is present in a cycle, only the highest-priority applicable event acts. Priority, highest first: `power_btn`, `lid_open`, `had_finish`, `start_btn`, `mode_btn`, `tick`.
- `power_btn`:
  - In SHUTDOWN: go to BEGIN and load `phase_cnt`=BEGIN_TICKS.
  - In any other state: go to SHUTDOWN and clear `phase_cnt`.
- BEGIN:
  - Each `tick` decrements `phase_cnt`.
  - On the tick where `phase_cnt` is 1: go to SET and set `phase_cnt`=0.
  - `start_btn`, `mode_btn` and `lid_open` are ignored.
- SET:
  - `mode_btn`: `prog` advances 0→1→2→3→0. `data` takes the matching PROGn on the same edge.
  - `start_btn` with `lid_open`=1: go to ERROR.
  - `start_btn` with `lid_open`=0: go to RUN.
- RUN:
  - `lid_open`: go to ERROR.
  - `had_finish`: go to FINISH and load `phase_cnt`=FINISH_TICKS.
  - `start_btn`: go to PAUSE.
  - `mode_btn` is ignored.
- PAUSE:
  - `lid_open`: go to ERROR.
  - `start_btn` with lid closed: go to RUN.
  - `mode_btn` is ignored.
- ERROR:
  - When `lid_open` falls to 0: go to PAUSE.
  - Buttons other than power are ignored.
- FINISH:
  - Each `tick` decrements `phase_cnt`.
  - On the tick where `phase_cnt` is 1: go to SHUTDOWN.
  - `prog` and `data` are held. Next power-on resumes the last program.
- `prog` and `data` change only on `mode_btn` in SET, or on reset.
- `buzzer` equals the registered decode of the next state, so it is valid in the same cycle as `state`.

## Timing
- Every transition takes effect on the `clk` edge that samples the causing input. Latency is 1 cycle from input to `state`.
- A `tick` arriving in the same cycle as entry to BEGIN or FINISH does not count. The counter is loaded, not decremented.
- BEGIN therefore lasts exactly BEGIN_TICKS tick edges after entry, and FINISH lasts FINISH_TICKS.
- Mid-operation reset: `rst_n` low forces all reset values immediately, independent of `clk`. The first `clk` edge after release acts normally.
- `had_finish` asserted in PAUSE or SET is ignored. It is acted on only in RUN.

## Test plan
- Reset, then `power_btn`, then 2 ticks.
  - Required: `state` goes 0→1 with `phase_cnt`=2, then 1, then `state`=2 with `phase_cnt`=0.
- In SET, 5 `mode_btn` pulses.
  - Required: `prog` steps 1,2,3,0,1. `data`=PROG1 after the last pulse.
- SET, `start_btn` with lid closed; then `lid_open`=1; then `lid_open`=0; then `start_btn`.
  - Required: `state` 3→4 (`buzzer`=1) →5 (`buzzer`=0) →3.
- RUN, assert `had_finish`, then 5 ticks.
  - Required: `state`=6, `phase_cnt` 5→1, `buzzer`=1, then `state`=0 and `buzzer`=0 on the 5th tick.
- RUN, `power_btn`, `lid_open` and `start_btn` all in one cycle.
  - Required: `state`=0. Next `power_btn` gives `state`=1 with `prog` unchanged.
- `rst_n` pulsed low mid-RUN between clock edges with `prog`=2.
  - Required: `state`=0, `prog`=0 and `data`=PROG0 immediately.
